// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared pipeline types and forward-select codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_USE = 2'd1,
        FROZEN   = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF      = 2'd0;
    localparam logic [1:0] FWD_MEM_ALU = 2'd1;
    localparam logic [1:0] FWD_MEM_LD  = 2'd2;
    localparam logic [1:0] FWD_WB      = 2'd3;

endpackage

`default_nettype wire

// File: rtl/fwd_operand_mux.sv
// ============================================================================
// Module      : fwd_operand_mux
// Description : Priority forwarding mux for one EX-stage source operand.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_operand_mux
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              rs_valid,
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   rf_operand,
    input  logic              mem_rd_we,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_alu_out,
    input  logic [XLEN-1:0]   mem_load_data,
    input  logic              wb_rd_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   operand,
    output logic [1:0]        sel
);

    // x0 is hardwired to zero, so it is never a forwarding target.
    always_comb begin
        operand = rf_operand;
        sel     = FWD_RF;
        if (rs_valid && (rs != '0)) begin
            if (mem_rd_we && (mem_rd == rs)) begin
                if (mem_is_load) begin
                    operand = mem_load_data;
                    sel     = FWD_MEM_LD;
                end else begin
                    operand = mem_alu_out;
                    sel     = FWD_MEM_ALU;
                end
            end else if (wb_rd_we && (wb_rd == rs)) begin
                operand = wb_data;
                sel     = FWD_WB;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Operand forwarding, load-use interlock, freeze FSM and counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hazard_unit
    import riscv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        id_rs_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        ex_rs_valid,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    input  logic [NUM_SRC*XLEN-1:0]   ex_operand,
    input  logic                      ex_rd_we,
    input  logic                      ex_is_load,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      mem_rd_we,
    input  logic                      mem_is_load,
    input  logic [REG_AW-1:0]         mem_rd,
    input  logic [XLEN-1:0]           mem_alu_out,
    input  logic [XLEN-1:0]           mem_load_data,
    input  logic                      mem_load_valid,
    input  logic                      wb_rd_we,
    input  logic [REG_AW-1:0]         wb_rd,
    input  logic [XLEN-1:0]           wb_data,
    output logic [NUM_SRC*XLEN-1:0]   ex_operand_sel,
    output logic [NUM_SRC*2-1:0]      fwd_src,
    output logic                      stall_id,
    output logic                      bubble_ex,
    output logic                      freeze,
    output logic                      load_timeout,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [1:0]                hz_state
);

    localparam int              WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);

    logic [NUM_SRC-1:0] w_lu_hit;
    logic [NUM_SRC-1:0] w_dw_hit;
    logic               w_ex_load_pending;
    logic               w_mem_load_waiting;
    logic               w_load_use;
    logic               w_dep_wait;

    hz_state_t          r_state;
    hz_state_t          w_state_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_load_timeout;
    logic [CNT_W-1:0]   r_stall_cnt;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            fwd_operand_mux #(
                .XLEN   (XLEN),
                .REG_AW (REG_AW)
            ) u_mux (
                .rs_valid      (ex_rs_valid[i]),
                .rs            (ex_rs[i*REG_AW +: REG_AW]),
                .rf_operand    (ex_operand[i*XLEN +: XLEN]),
                .mem_rd_we     (mem_rd_we),
                .mem_is_load   (mem_is_load),
                .mem_rd        (mem_rd),
                .mem_alu_out   (mem_alu_out),
                .mem_load_data (mem_load_data),
                .wb_rd_we      (wb_rd_we),
                .wb_rd         (wb_rd),
                .wb_data       (wb_data),
                .operand       (ex_operand_sel[i*XLEN +: XLEN]),
                .sel           (fwd_src[i*2 +: 2])
            );

            assign w_lu_hit[i] = id_rs_valid[i] && (id_rs[i*REG_AW +: REG_AW] == ex_rd);
            assign w_dw_hit[i] = ex_rs_valid[i] && (ex_rs[i*REG_AW +: REG_AW] == mem_rd);
        end
    endgenerate

    assign w_ex_load_pending  = ex_is_load && ex_rd_we && (ex_rd != '0);
    assign w_mem_load_waiting = mem_is_load && mem_rd_we && (mem_rd != '0) && !mem_load_valid;
    assign w_load_use         = w_ex_load_pending && (|w_lu_hit);
    assign w_dep_wait         = w_mem_load_waiting && (|w_dw_hit);

    // A freeze holds every stage, so the bubble would be lost; freeze wins.
    assign freeze    = w_dep_wait;
    assign stall_id  = w_load_use && !w_dep_wait;
    assign bubble_ex = w_load_use && !w_dep_wait;

    always_comb begin
        w_state_next = IDLE;
        case (r_state)
            IDLE, LOAD_USE, FROZEN: begin
                if (w_dep_wait) begin
                    w_state_next = FROZEN;
                end else if (w_load_use) begin
                    w_state_next = LOAD_USE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counts consecutive frozen cycles; the timeout flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt     <= '0;
            r_load_timeout <= 1'b0;
        end else if ((r_state == FROZEN) && w_dep_wait) begin
            if (r_wait_cnt != C_MAX_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (r_wait_cnt >= (C_MAX_WAIT - WAIT_W'(1))) begin
                r_load_timeout <= 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((stall_id || freeze) && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign load_timeout = r_load_timeout;
    assign stall_cnt    = r_stall_cnt;
    assign hz_state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// ============================================================================
// Module      : tb_fwd_hazard_unit
// Description : Directed vectors and multi-cycle sequences for fwd_hazard_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_hazard_unit;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_SRC  = 2;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;

    localparam logic [XLEN-1:0] C_RF0   = 32'hA0A0_A0A0;
    localparam logic [XLEN-1:0] C_RF1   = 32'hB0B0_B0B1;
    localparam logic [XLEN-1:0] C_ALU   = 32'h0000_0011;
    localparam logic [XLEN-1:0] C_LD    = 32'h0000_CAFE;
    localparam logic [XLEN-1:0] C_WB    = 32'h0000_0022;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_SRC-1:0]        id_rs_valid;
    logic [NUM_SRC*REG_AW-1:0] id_rs;
    logic [NUM_SRC-1:0]        ex_rs_valid;
    logic [NUM_SRC*REG_AW-1:0] ex_rs;
    logic [NUM_SRC*XLEN-1:0]   ex_operand;
    logic                      ex_rd_we;
    logic                      ex_is_load;
    logic [REG_AW-1:0]         ex_rd;
    logic                      mem_rd_we;
    logic                      mem_is_load;
    logic [REG_AW-1:0]         mem_rd;
    logic [XLEN-1:0]           mem_alu_out;
    logic [XLEN-1:0]           mem_load_data;
    logic                      mem_load_valid;
    logic                      wb_rd_we;
    logic [REG_AW-1:0]         wb_rd;
    logic [XLEN-1:0]           wb_data;
    logic [NUM_SRC*XLEN-1:0]   ex_operand_sel;
    logic [NUM_SRC*2-1:0]      fwd_src;
    logic                      stall_id;
    logic                      bubble_ex;
    logic                      freeze;
    logic                      load_timeout;
    logic [CNT_W-1:0]          stall_cnt;
    logic [1:0]                hz_state;

    int total = 0;
    int bad   = 0;

    fwd_hazard_unit #(
        .XLEN     (XLEN),
        .REG_AW   (REG_AW),
        .NUM_SRC  (NUM_SRC),
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs_valid    (id_rs_valid),
        .id_rs          (id_rs),
        .ex_rs_valid    (ex_rs_valid),
        .ex_rs          (ex_rs),
        .ex_operand     (ex_operand),
        .ex_rd_we       (ex_rd_we),
        .ex_is_load     (ex_is_load),
        .ex_rd          (ex_rd),
        .mem_rd_we      (mem_rd_we),
        .mem_is_load    (mem_is_load),
        .mem_rd         (mem_rd),
        .mem_alu_out    (mem_alu_out),
        .mem_load_data  (mem_load_data),
        .mem_load_valid (mem_load_valid),
        .wb_rd_we       (wb_rd_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .ex_operand_sel (ex_operand_sel),
        .fwd_src        (fwd_src),
        .stall_id       (stall_id),
        .bubble_ex      (bubble_ex),
        .freeze         (freeze),
        .load_timeout   (load_timeout),
        .stall_cnt      (stall_cnt),
        .hz_state       (hz_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] exv;
        logic [4:0] exr0;
        logic [4:0] exr1;
        logic       mwe;
        logic       mld;
        logic [4:0] mrd;
        logic       mlv;
        logic       wwe;
        logic [4:0] wrd;
        logic [1:0] idv;
        logic [4:0] idr0;
        logic [4:0] idr1;
        logic       ewe;
        logic       eld;
        logic [4:0] erd;
        logic [1:0] exp_s0;
        logic [1:0] exp_s1;
        logic       exp_stall;
        logic       exp_frz;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_val(input logic [1:0] code, input logic [XLEN-1:0] rf);
        case (code)
            2'd1:    exp_val = C_ALU;
            2'd2:    exp_val = C_LD;
            2'd3:    exp_val = C_WB;
            default: exp_val = rf;
        endcase
    endfunction

    task automatic clear_inputs();
        id_rs_valid    = '0;
        id_rs          = '0;
        ex_rs_valid    = '0;
        ex_rs          = '0;
        ex_operand     = {C_RF1, C_RF0};
        ex_rd_we       = 1'b0;
        ex_is_load     = 1'b0;
        ex_rd          = '0;
        mem_rd_we      = 1'b0;
        mem_is_load    = 1'b0;
        mem_rd         = '0;
        mem_alu_out    = C_ALU;
        mem_load_data  = C_LD;
        mem_load_valid = 1'b0;
        wb_rd_we       = 1'b0;
        wb_rd          = '0;
        wb_data        = C_WB;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Load in EX writing x7, consumer in ID reading x7 through source 1.
    task automatic drive_bubble();
        clear_inputs();
        id_rs_valid = 2'b10;
        id_rs       = {5'd7, 5'd0};
        ex_rd_we    = 1'b1;
        ex_is_load  = 1'b1;
        ex_rd       = 5'd7;
    endtask

    // Consumer has moved to EX, the load is in MEM.
    task automatic drive_consumer(input logic valid);
        clear_inputs();
        ex_rs_valid    = 2'b10;
        ex_rs          = {5'd7, 5'd0};
        mem_rd_we      = 1'b1;
        mem_is_load    = 1'b1;
        mem_rd         = 5'd7;
        mem_load_valid = valid;
    endtask

    initial begin
        //            name      exv   r0  r1  mwe mld mrd mlv wwe wrd idv  ir0 ir1 ewe eld erd s0 s1 st fz
        vecs[0]  = '{"mem_over_wb", 2'b01, 5, 0, 1, 0, 5, 1, 1, 5, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[1]  = '{"x0_no_fwd",   2'b11, 0, 0, 1, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{"wb_only",     2'b11, 3, 9, 1, 0, 4, 1, 1, 9, 2'b00, 0, 0, 0, 0, 0, 0, 3, 0, 0};
        vecs[3]  = '{"mem_ld_both", 2'b11, 6, 6, 1, 1, 6, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2, 2, 0, 0};
        vecs[4]  = '{"wb_both",     2'b11, 6, 6, 0, 0, 6, 1, 1, 6, 2'b00, 0, 0, 0, 0, 0, 3, 3, 0, 0};
        vecs[5]  = '{"src_invalid", 2'b10, 5, 5, 1, 0, 5, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        vecs[6]  = '{"load_use",    2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 0, 7, 1, 1, 7, 0, 0, 1, 0};
        vecs[7]  = '{"lu_rd_x0",    2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 2'b11, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[8]  = '{"lu_id_inv",   2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 7, 7, 1, 1, 7, 0, 0, 0, 0};
        vecs[9]  = '{"lu_no_we",    2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 2'b11, 7, 7, 0, 1, 7, 0, 0, 0, 0};
        vecs[10] = '{"frz_dom",     2'b01, 8, 0, 1, 1, 8, 0, 0, 0, 2'b10, 0, 7, 1, 1, 7, 2, 0, 0, 1};
        vecs[11] = '{"dw_no_match", 2'b01, 9, 0, 1, 1, 8, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{"dw_rd_x0",    2'b01, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        clear_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_state",    64'(hz_state), 64'd0);
        chk("rst_cnt",      64'(stall_cnt), 64'd0);
        chk("rst_timeout",  64'(load_timeout), 64'd0);
        chk("rst_stall",    64'(stall_id), 64'd0);
        chk("rst_freeze",   64'(freeze), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            clear_inputs();
            ex_rs_valid    = vecs[i].exv;
            ex_rs          = {vecs[i].exr1, vecs[i].exr0};
            mem_rd_we      = vecs[i].mwe;
            mem_is_load    = vecs[i].mld;
            mem_rd         = vecs[i].mrd;
            mem_load_valid = vecs[i].mlv;
            wb_rd_we       = vecs[i].wwe;
            wb_rd          = vecs[i].wrd;
            id_rs_valid    = vecs[i].idv;
            id_rs          = {vecs[i].idr1, vecs[i].idr0};
            ex_rd_we       = vecs[i].ewe;
            ex_is_load     = vecs[i].eld;
            ex_rd          = vecs[i].erd;
            #1;
            chk({vecs[i].name, ".src"}, 64'(fwd_src), 64'({vecs[i].exp_s1, vecs[i].exp_s0}));
            chk({vecs[i].name, ".op0"}, 64'(ex_operand_sel[XLEN-1:0]), 64'(exp_val(vecs[i].exp_s0, C_RF0)));
            chk({vecs[i].name, ".op1"}, 64'(ex_operand_sel[2*XLEN-1:XLEN]), 64'(exp_val(vecs[i].exp_s1, C_RF1)));
            chk({vecs[i].name, ".stall"}, 64'(stall_id), 64'(vecs[i].exp_stall));
            chk({vecs[i].name, ".bubble"}, 64'(bubble_ex), 64'(vecs[i].exp_stall));
            chk({vecs[i].name, ".freeze"}, 64'(freeze), 64'(vecs[i].exp_frz));
        end

        // Load-use with data returning right after the bubble.
        do_reset();
        drive_bubble();
        #1;
        chk("lu.stall", 64'(stall_id), 64'd1);
        chk("lu.bubble", 64'(bubble_ex), 64'd1);
        @(negedge clk);
        chk("lu.state1", 64'(hz_state), 64'd1);
        drive_consumer(1'b1);
        #1;
        chk("lu.stall_off", 64'(stall_id), 64'd0);
        chk("lu.freeze_off", 64'(freeze), 64'd0);
        chk("lu.op1", 64'(ex_operand_sel[2*XLEN-1:XLEN]), 64'(C_LD));
        chk("lu.src", 64'(fwd_src), 64'h8);
        @(negedge clk);
        chk("lu.idle", 64'(hz_state), 64'd0);
        chk("lu.cnt", 64'(stall_cnt), 64'd1);

        // Load data late by three cycles.
        do_reset();
        drive_bubble();
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            drive_consumer(1'b0);
            #1;
            chk("dl.freeze", 64'(freeze), 64'd1);
            chk("dl.stall_masked", 64'(stall_id), 64'd0);
            chk("dl.state", 64'(hz_state), (k == 1) ? 64'd1 : 64'd2);
            @(negedge clk);
        end
        drive_consumer(1'b1);
        #1;
        chk("dl.release", 64'(freeze), 64'd0);
        chk("dl.state_rel", 64'(hz_state), 64'd2);
        @(negedge clk);
        chk("dl.idle", 64'(hz_state), 64'd0);
        chk("dl.cnt", 64'(stall_cnt), 64'd4);
        chk("dl.no_timeout", 64'(load_timeout), 64'd0);

        // Held-off load data: timeout, counter saturation, sticky flag.
        do_reset();
        drive_bubble();
        @(negedge clk);
        for (int k = 1; k <= 20; k++) begin
            drive_consumer(1'b0);
            #1;
            if (freeze !== 1'b1) chk("to.freeze", 64'(freeze), 64'd1);
            if (k == 5)  chk("to.before", 64'(load_timeout), 64'd0);
            if (k == 6)  chk("to.set", 64'(load_timeout), 64'd1);
            if (k == 15) chk("to.cnt15", 64'(stall_cnt), 64'd15);
            @(negedge clk);
        end
        chk("to.freeze_held", 64'(freeze), 64'd1);
        chk("to.cnt_sat", 64'(stall_cnt), 64'd15);
        drive_consumer(1'b1);
        @(negedge clk);
        chk("to.idle", 64'(hz_state), 64'd0);
        chk("to.sticky", 64'(load_timeout), 64'd1);

        // Asynchronous reset between edges while frozen.
        drive_consumer(1'b0);
        @(negedge clk);
        chk("ar.frozen", 64'(hz_state), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.state", 64'(hz_state), 64'd0);
        chk("ar.cnt", 64'(stall_cnt), 64'd0);
        chk("ar.timeout", 64'(load_timeout), 64'd0);
        chk("ar.freeze_comb", 64'(freeze), 64'd1);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

- Parametrised operand-forwarding and load-use interlock unit for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Provides N independent EX-stage source operands, each forwarded from the youngest in-flight producer, with MEM taking priority over WB.
- Detects load-use hazards at ID and inserts exactly one bubble. Freezes the pipeline while a dependent load's data is not yet valid.
- Keeps a wait-timeout flag and a stall performance counter.

## Interface

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width
- NUM_SRC, 2, number of source operands per instruction (1..4)
- MAX_WAIT, 15, maximum consecutive freeze cycles before `load_timeout` is set
- CNT_W, 32, width of the stall counter

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  pipeline clock
  - rst_n  in  1  asynchronous active-low reset
- ID-stage sources (source i occupies bits [i*REG_AW +: REG_AW]):
  - id_rs_valid  in  NUM_SRC  ID-stage source valid, one bit per source
  - id_rs  in  NUM_SRC*REG_AW  ID-stage source addresses
- EX-stage sources (operand i occupies bits [i*XLEN +: XLEN]):
  - ex_rs_valid  in  NUM_SRC  EX-stage source valid
  - ex_rs  in  NUM_SRC*REG_AW  EX-stage source addresses
  - ex_operand  in  NUM_SRC*XLEN  register-file read values
- EX-stage producer:
  - ex_rd_we, ex_is_load  in  1 each  EX instruction writes rd / is a load
  - ex_rd  in  REG_AW  EX destination
- MEM-stage producer:
  - mem_rd_we, mem_is_load  in  1 each  MEM instruction writes rd / is a load
  - mem_rd  in  REG_AW  MEM destination
  - mem_alu_out  in  XLEN  ALU result in MEM
  - mem_load_data  in  XLEN  load data returned from memory
  - mem_load_valid  in  1  mem_load_data is valid this cycle
- WB-stage producer:
  - wb_rd_we  in  1  WB instruction writes rd
  - wb_rd  in  REG_AW  WB destination
  - wb_data  in  XLEN  WB write-back value
- Outputs:
  - ex_operand_sel  out  NUM_SRC*XLEN  forwarded operands
  - fwd_src  out  NUM_SRC*2  per-source select: 0 RF, 1 MEM ALU, 2 MEM load, 3 WB
  - stall_id  out  1  hold PC and IF/ID
  - bubble_ex  out  1  load NOP into ID/EX
  - freeze  out  1  hold all pipeline registers
  - load_timeout  out  1  sticky error flag
  - stall_cnt  out  CNT_W  saturating count of stall/freeze cycles
  - hz_state  out  2  FSM state, for debug

## Operation

Forwarding (combinational, per source i), evaluated in this priority order:
1. If `!ex_rs_valid[i]` or `rs==0`: pass `ex_operand`, code 0. Register x0 is never forwarded.
2. If `mem_rd_we`, `mem_rd==rs` and `!mem_is_load`: forward `mem_alu_out`, code 1.
3. If `mem_rd_we`, `mem_rd==rs` and `mem_is_load`: forward `mem_load_data`, code 2.
4. If `wb_rd_we` and `wb_rd==rs`: forward `wb_data`, code 3.
5. Otherwise: pass `ex_operand`, code 0.

Hazard terms:
- load_use = `ex_is_load & ex_rd_we & (ex_rd!=0)` and, for some i, `id_rs_valid[i] & id_rs[i]==ex_rd`.
- dep_wait = `mem_is_load & mem_rd_we & (mem_rd!=0) & !mem_load_valid` and, for some i, `ex_rs_valid[i] & ex_rs[i]==mem_rd`.
- `freeze` = dep_wait.
- `stall_id` = `bubble_ex` = load_use & !freeze. Freeze dominates.

FSM (`hz_state`):
- IDLE (0): on load_use & !freeze, go to LOAD_USE. On freeze, go to FROZEN.
- LOAD_USE (1): the consumer is in EX and the load is in MEM.
  - freeze → FROZEN.
  - Otherwise, load_use → stay in LOAD_USE (new bubble).
  - Otherwise → IDLE.
- FROZEN (2): stays while freeze is asserted.
  - On release: load_use → LOAD_USE, otherwise → IDLE.
- State 3 is illegal; it recovers to IDLE.

Wait counter:
- Counts consecutive FROZEN cycles and clears on leaving FROZEN.
- When the count reaches MAX_WAIT, `load_timeout` sets. It clears only on reset.
- Freeze is still held after timeout.

Stall counter:
- `stall_cnt` increments on every cycle where `stall_id|freeze` is asserted.
- It saturates at all-ones.

## Timing

- Forwarding and stall/freeze outputs are combinational in the same cycle as the inputs. The FSM and counters update on the rising edge of clk.
- A load-use hazard costs exactly 1 bubble cycle when `mem_load_valid` arrives in the cycle after the bubble. Each additional cycle of invalid load data adds 1 freeze cycle.
- Reset (asynchronous, mid-operation included):
  - State goes to IDLE; the wait counter, `stall_cnt` and `load_timeout` go to 0.
  - `stall_id`, `bubble_ex` and `freeze` follow the combinational terms. With all valid inputs at 0 they are 0.
- MEM and WB writing the same rd: the MEM value wins.
- Multiple sources matching one producer are all forwarded.

## Structure

- The shared pipeline package (`riscv_pkg`) holds:
  - the `hz_state_t` enum (IDLE, LOAD_USE, FROZEN);
  - the forward-select constants `FWD_RF`, `FWD_MEM_ALU`, `FWD_MEM_LD`, `FWD_WB`.
- Sub-module `fwd_operand_mux`: one source's priority mux, instantiated NUM_SRC times via generate.
- The top level holds the hazard terms, the FSM and the counters.

## Test plan

- MEM ALU vs WB priority: rs1=5; `mem_rd=5` (we=1, ALU) with `mem_alu_out=0x11`; `wb_rd=5` (we=1) with `wb_data=0x22` → operand 0x11, `fwd_src`=1.
- x0 never forwarded: rs1=0; `mem_rd=0`, we=1, `mem_alu_out=0xDEAD`; `ex_operand=0` → operand 0, `fwd_src`=0.
- Load-use, 1 bubble: EX load rd=7, ID rs2=7 → `stall_id`=`bubble_ex`=1 for 1 cycle. Next cycle, with `mem_load_valid=1` and `mem_load_data=0xCAFE`: EX operand 0xCAFE, code 2, state back to IDLE, `stall_cnt`=1.
- Delayed load data: as above but `mem_load_valid`=0 for 3 cycles → `freeze`=1 for 3 cycles, `hz_state`=FROZEN, `stall_cnt`=4, then release.
- Timeout: MAX_WAIT=4 with `mem_load_valid` held at 0 → `load_timeout` rises after 4 FROZEN cycles and stays set after release until `rst_n` is low.
- Asynchronous reset while FROZEN: assert `rst_n`=0 between clock edges → state becomes IDLE and counters become 0 immediately, without waiting for a clock edge.
